// File: rtl/pll_md_reconfig.sv
// Reconfigures the HDMI PLL through its MD port: it holds the PLL in reset, writes a
// register profile, reads the profile back to verify it, then releases reset and waits for lock.
module pll_md_reconfig #(
  parameter int unsigned           NUM_REGS     = 4,
  parameter logic [7:0]            BASE_ADDR    = 8'h00,
  parameter logic [NUM_REGS*8-1:0] PROFILE0     = '0,
  parameter logic [NUM_REGS*8-1:0] PROFILE1     = '0,
  parameter int unsigned           RD_LAT       = 2,
  parameter int unsigned           RST_HOLD     = 16,
  parameter int unsigned           LOCK_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       profile_sel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic       pll_reset,
  input  logic       pll_lock,
  output logic [1:0] md_opc,
  output logic       md_ainc,
  output logic [7:0] md_wdi,
  input  logic [7:0] md_rdo
);

  localparam int unsigned IdxW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned HoldW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int unsigned LatW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned ToW   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_REGS - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);
  localparam logic [LatW-1:0]  LatLast  = LatW'(RD_LAT - 1);
  localparam logic [ToW-1:0]   ToLast   = ToW'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpAddr  = 2'b11;

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StHold     = 4'd1;
  localparam logic [3:0] StWaddr    = 4'd2;
  localparam logic [3:0] StWrite    = 4'd3;
  localparam logic [3:0] StRaddr    = 4'd4;
  localparam logic [3:0] StRead     = 4'd5;
  localparam logic [3:0] StRwait    = 4'd6;
  localparam logic [3:0] StCheck    = 4'd7;
  localparam logic [3:0] StRelease  = 4'd8;
  localparam logic [3:0] StLockwait = 4'd9;

  logic [3:0]       state_q, state_d;
  logic             sel_q, sel_d;
  logic [IdxW-1:0]  idx_q, idx_d, idx_inc;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [LatW-1:0]  lat_cnt_q, lat_cnt_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]       rdo_q, rdo_d;
  logic             lock_meta_q, lock_sync_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             pll_reset_q, pll_reset_d;
  logic [1:0]       md_opc_q, md_opc_d;
  logic             md_ainc_q, md_ainc_d;
  logic [7:0]       md_wdi_q, md_wdi_d;

  function automatic logic [7:0] prof_byte(input logic sel, input logic [IdxW-1:0] i);
    logic [NUM_REGS*8-1:0] p;
    p = sel ? PROFILE1 : PROFILE0;
    return p[{i, 3'b000} +: 8];
  endfunction

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    hold_cnt_d  = hold_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    to_cnt_d    = to_cnt_q;
    rdo_d       = rdo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    err_code_d  = err_code_q;
    pll_reset_d = pll_reset_q;
    md_opc_d    = OpNop;
    md_ainc_d   = 1'b0;
    md_wdi_d    = md_wdi_q;
    // Outputs are registered, so each branch sets the values for the state being entered.
    case (state_q)
      StIdle: begin
        if (start) begin
          sel_d       = profile_sel;
          err_code_d  = 2'b00;
          busy_d      = 1'b1;
          pll_reset_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d  = StWaddr;
          md_opc_d = OpAddr;
          md_wdi_d = BASE_ADDR;
          idx_d    = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StWaddr: begin
        state_d   = StWrite;
        md_opc_d  = OpWrite;
        md_ainc_d = 1'b1;
        md_wdi_d  = prof_byte(sel_q, idx_q);
      end
      StWrite: begin
        if (idx_q == IdxLast) begin
          state_d  = StRaddr;
          md_opc_d = OpAddr;
          md_wdi_d = BASE_ADDR;
          idx_d    = '0;
        end else begin
          idx_d     = idx_inc;
          md_opc_d  = OpWrite;
          md_ainc_d = 1'b1;
          md_wdi_d  = prof_byte(sel_q, idx_inc);
        end
      end
      StRaddr: begin
        state_d   = StRead;
        md_opc_d  = OpRead;
        md_ainc_d = 1'b1;
      end
      StRead: begin
        state_d   = StRwait;
        lat_cnt_d = '0;
      end
      StRwait: begin
        if (lat_cnt_q == LatLast) begin
          rdo_d   = md_rdo;
          state_d = StCheck;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      StCheck: begin
        if (rdo_q != prof_byte(sel_q, idx_q)) begin
          err_code_d  = 2'b01;
          error_d     = 1'b1;
          busy_d      = 1'b0;
          pll_reset_d = 1'b0;
          state_d     = StIdle;
        end else if (idx_q == IdxLast) begin
          pll_reset_d = 1'b0;
          state_d     = StRelease;
        end else begin
          idx_d     = idx_inc;
          state_d   = StRead;
          md_opc_d  = OpRead;
          md_ainc_d = 1'b1;
        end
      end
      StRelease: begin
        to_cnt_d = '0;
        state_d  = StLockwait;
      end
      StLockwait: begin
        if (lock_sync_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (to_cnt_q == ToLast) begin
          err_code_d = 2'b10;
          error_d    = 1'b1;
          busy_d     = 1'b0;
          state_d    = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sel_q       <= 1'b0;
      idx_q       <= '0;
      hold_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      to_cnt_q    <= '0;
      rdo_q       <= '0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'b00;
      pll_reset_q <= 1'b0;
      md_opc_q    <= OpNop;
      md_ainc_q   <= 1'b0;
      md_wdi_q    <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      hold_cnt_q  <= hold_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      to_cnt_q    <= to_cnt_d;
      rdo_q       <= rdo_d;
      lock_meta_q <= pll_lock;
      // Second stage only passes lock while waiting, so pre-release glitches cannot leak in.
      lock_sync_q <= (state_q == StLockwait) ? lock_meta_q : 1'b0;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      pll_reset_q <= pll_reset_d;
      md_opc_q    <= md_opc_d;
      md_ainc_q   <= md_ainc_d;
      md_wdi_q    <= md_wdi_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign pll_reset = pll_reset_q;
  assign md_opc    = md_opc_q;
  assign md_ainc   = md_ainc_q;
  assign md_wdi    = md_wdi_q;

endmodule
